// File: rtl/router_ingress_ctrl.sv
// rtl/router_ingress_ctrl.sv - 1x3 router ingress control: steers header/payload/parity into per-port FIFOs,
// checks parity, back-pressures the source and flushes FIFOs that go unread for too long.
module router_ingress_ctrl #(
  parameter int NUM_PORTS = 3,
  parameter int TIMEOUT   = 30
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [7:0]           data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] read_enb,
  output logic [7:0]           data_out,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 lfd_state,
  output logic                 busy,
  output logic                 err,
  output logic [NUM_PORTS-1:0] valid_out,
  output logic [NUM_PORTS-1:0] soft_reset
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EMPTY,
    S_LOAD_HDR,
    S_LOAD_DATA,
    S_CHECK_PARITY,
    S_DROP
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           hdr_q, hdr_d;
  logic [7:0]           parity_q, parity_d;
  logic [7:0]           pbyte_q, pbyte_d;
  logic                 err_q, err_d;
  logic [NUM_PORTS-1:0] sr_q, sr_d;
  logic [4:0]           cnt_q [NUM_PORTS];
  logic [4:0]           cnt_d [NUM_PORTS];

  logic [NUM_PORTS-1:0] in_sel, act_sel;
  logic                 in_hdr_ok, in_empty, act_empty, act_full, abort;
  logic                 hdr_take, pay_take, par_take;

  // Address values with no matching port decode to all-zero, which marks the header as droppable.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] a);
    logic [NUM_PORTS-1:0] oh;
    for (int i = 0; i < NUM_PORTS; i++) oh[i] = (a == 2'(i));
    return oh;
  endfunction

  assign in_sel    = port_onehot(data_in[1:0]);
  assign act_sel   = port_onehot(hdr_q[1:0]);
  assign in_hdr_ok = |in_sel;
  assign in_empty  = |(fifo_empty & in_sel);
  assign act_empty = |(fifo_empty & act_sel);
  assign act_full  = |(fifo_full & act_sel);
  assign abort     = (|(sr_q & act_sel)) &&
                     (state_q inside {S_WAIT_EMPTY, S_LOAD_HDR, S_LOAD_DATA});

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pkt_valid) begin
          if (!in_hdr_ok)    state_d = S_DROP;
          else if (in_empty) state_d = S_LOAD_HDR;
          else               state_d = S_WAIT_EMPTY;
        end
      end
      S_WAIT_EMPTY: begin
        if (abort)          state_d = S_DROP;
        else if (act_empty) state_d = S_LOAD_HDR;
      end
      // A full flag here is unexpected, but holding off keeps the header from being lost.
      S_LOAD_HDR: begin
        if (abort)          state_d = S_DROP;
        else if (!act_full) state_d = S_LOAD_DATA;
      end
      S_LOAD_DATA: begin
        if (abort)                       state_d = S_DROP;
        else if (!act_full && !pkt_valid) state_d = S_CHECK_PARITY;
      end
      S_CHECK_PARITY: state_d = S_IDLE;
      S_DROP: begin
        if (!pkt_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    write_enb = '0;
    data_out  = 8'h00;
    lfd_state = 1'b0;
    busy      = 1'b0;
    hdr_take  = 1'b0;
    pay_take  = 1'b0;
    par_take  = 1'b0;
    case (state_q)
      S_IDLE: hdr_take = pkt_valid && in_hdr_ok;
      S_WAIT_EMPTY: busy = 1'b1;
      S_LOAD_HDR: begin
        busy = 1'b1;
        if (!abort && !act_full) begin
          write_enb = act_sel;
          data_out  = hdr_q;
          lfd_state = 1'b1;
        end
      end
      S_LOAD_DATA: begin
        busy = act_full;
        if (!abort && !act_full) begin
          write_enb = act_sel;
          data_out  = data_in;
          pay_take  = pkt_valid;
          par_take  = !pkt_valid;
        end
      end
      S_CHECK_PARITY: busy = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    hdr_d    = hdr_q;
    parity_d = parity_q;
    pbyte_d  = pbyte_q;
    err_d    = err_q;
    if (hdr_take) begin
      hdr_d    = data_in;
      parity_d = data_in;
      err_d    = 1'b0;
    end
    if (pay_take) parity_d = parity_q ^ data_in;
    if (par_take) pbyte_d = data_in;
    if (state_q == S_CHECK_PARITY) err_d = (pbyte_q != parity_q);
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      sr_d[i]  = 1'b0;
      if (fifo_empty[i] || read_enb[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == 5'(TIMEOUT - 1)) begin
        cnt_d[i] = '0;
        sr_d[i]  = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 5'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hdr_q    <= 8'h00;
      parity_q <= 8'h00;
      pbyte_q  <= 8'h00;
      err_q    <= 1'b0;
      sr_q     <= '0;
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      hdr_q    <= hdr_d;
      parity_q <= parity_d;
      pbyte_q  <= pbyte_d;
      err_q    <= err_d;
      sr_q     <= sr_d;
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign err        = err_q;
  assign soft_reset = sr_q;
  assign valid_out  = ~fifo_empty;

endmodule

// File: tb/tb_router_ingress_ctrl.sv
// tb/tb_router_ingress_ctrl.sv - self-checking bench for router_ingress_ctrl: packet table, corner sequences,
// random packets against a byte-queue scoreboard.
module tb_router_ingress_ctrl;

  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full, fifo_empty, read_enb;
  logic [7:0] data_out;
  logic [2:0] write_enb, valid_out, soft_reset;
  logic       lfd_state, busy, err;

  router_ingress_ctrl #(.NUM_PORTS(3), .TIMEOUT(30)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
    .data_out(data_out), .write_enb(write_enb), .lfd_state(lfd_state), .busy(busy),
    .err(err), .valid_out(valid_out), .soft_reset(soft_reset)
  );

  typedef struct {
    logic [7:0]  hdr;
    logic [31:0] pl;
    int          n;
    logic [7:0]  par;
    int          stall_at;
    int          stall_len;
    logic        exp_err;
    int          exp_wr;
  } pkt_vec_t;

  pkt_vec_t   tbl [8];
  int         vectors, miscompares, wr_count;
  logic       err_m, rnd_en;
  logic [8:0] exp_q [3][$];
  logic [7:0] cur_pl [$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [2:0] ve;
    logic [8:0] e;
    forever begin
      @(negedge clock);
      if (resetn) begin
        ve = ~fifo_empty;
        check("valid_out", 32'(valid_out), 32'(ve));
        if (write_enb != 3'b000) begin
          wr_count++;
          check("write_onehot", 32'($onehot(write_enb)), 32'd1);
          check("write_while_full", 32'(write_enb & fifo_full), 32'd0);
          for (int p = 0; p < 3; p++) begin
            if (write_enb[p]) begin
              if (exp_q[p].size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: port %0d got data 0x%0h lfd %0b, required no write", p, data_out, lfd_state);
              end else begin
                e = exp_q[p].pop_front();
                check("fifo_byte", 32'({lfd_state, data_out}), 32'(e));
              end
            end
          end
        end else begin
          check("lfd_without_write", 32'(lfd_state), 32'd0);
        end
      end
    end
  endtask

  task automatic rand_fifo();
    forever begin
      @(posedge clock);
      #1;
      if (rnd_en) begin
        fifo_full  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
        fifo_empty = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b111;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte has been taken.
  task automatic send_byte(input logic v, input logic [7:0] d, output int waits);
    pkt_valid = v;
    data_in   = d;
    waits     = 0;
    @(negedge clock);
    while (busy && waits < 200) begin
      @(negedge clock);
      waits++;
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: busy still 1 after 200 cycles, required 0");
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run_pkt(input logic [7:0] hdr, input logic [7:0] par, input int stall_at,
                         input int stall_len, output logic err_seen, output int nwr);
    int         p, w, wr0;
    logic [7:0] acc;
    p   = int'(hdr[1:0]);
    wr0 = wr_count;
    acc = hdr;
    if (p < 3) begin
      exp_q[p].push_back({1'b1, hdr});
      foreach (cur_pl[k]) exp_q[p].push_back({1'b0, cur_pl[k]});
      exp_q[p].push_back({1'b0, par});
    end
    send_byte(1'b1, hdr, w);
    if (p < 3) begin
      check("err_clear_on_hdr", 32'(err), 32'd0);
      err_m = 1'b0;
    end
    foreach (cur_pl[k]) begin
      if (k == stall_at && p < 3) begin
        pkt_valid    = 1'b1;
        data_in      = cur_pl[k];
        fifo_full[p] = 1'b1;
        repeat (stall_len) begin
          @(negedge clock);
          check("stall_busy", 32'(busy), 32'd1);
          check("stall_no_write", 32'(write_enb), 32'd0);
          @(posedge clock);
          #1;
        end
        fifo_full[p] = 1'b0;
        send_byte(1'b1, cur_pl[k], w);
        check("stall_release_wait", 32'(w), 32'd0);
      end else begin
        send_byte(1'b1, cur_pl[k], w);
      end
    end
    send_byte(1'b0, par, w);
    @(posedge clock);
    #1;
    if (p < 3) begin
      foreach (cur_pl[k]) acc ^= cur_pl[k];
      err_m = (par != acc);
      check("all_bytes_written", 32'(exp_q[p].size()), 32'd0);
    end
    err_seen = err;
    nwr      = wr_count - wr0;
  endtask

  initial begin
    logic       es, exp_e;
    int         nw, w, n, len, exp_w;
    logic [1:0] a;
    logic [7:0] h, par, acc, b;

    vectors = 0; miscompares = 0; wr_count = 0; err_m = 1'b0; rnd_en = 1'b0;
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 8'h00;
    fifo_full = 3'b000; fifo_empty = 3'b111; read_enb = 3'b111;

    tbl[0] = '{8'h0D, 32'h00332211, 3, 8'h0D, -1, 0, 1'b0, 5};
    tbl[1] = '{8'h0D, 32'h00332211, 3, 8'h00, -1, 0, 1'b1, 5};
    tbl[2] = '{8'h10, 32'hDDCCBBAA, 4, 8'h10,  2, 4, 1'b0, 6};
    tbl[3] = '{8'h0B, 32'h00005544, 2, 8'h1A, -1, 0, 1'b0, 0};
    tbl[4] = '{8'h0D, 32'h00332211, 3, 8'h0D, -1, 0, 1'b0, 5};
    tbl[5] = '{8'h0E, 32'h00040201, 3, 8'hFF, -1, 0, 1'b1, 5};
    tbl[6] = '{8'h0B, 32'h00005544, 2, 8'h1A, -1, 0, 1'b1, 0};
    tbl[7] = '{8'h04, 32'h00000080, 1, 8'h84, -1, 0, 1'b0, 3};

    fork
      monitor();
      rand_fifo();
      begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_write_enb", 32'(write_enb), 32'd0);
    check("rst_lfd", 32'(lfd_state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_soft_reset", 32'(soft_reset), 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;

    for (int r = 0; r < 8; r++) begin
      cur_pl.delete();
      for (int k = 0; k < tbl[r].n; k++) cur_pl.push_back(tbl[r].pl[8*k +: 8]);
      run_pkt(tbl[r].hdr, tbl[r].par, tbl[r].stall_at, tbl[r].stall_len, es, nw);
      check("tbl_err", 32'(es), 32'(tbl[r].exp_err));
      check("tbl_writes", 32'(nw), 32'(tbl[r].exp_wr));
    end

    // Header to a non-empty port waits until the FIFO drains.
    fifo_empty = 3'b011;
    exp_q[2].push_back({1'b1, 8'h06});
    exp_q[2].push_back({1'b0, 8'h5A});
    exp_q[2].push_back({1'b0, 8'h5C});
    send_byte(1'b1, 8'h06, w);
    check("wait_hdr_taken", 32'(w), 32'd0);
    data_in = 8'h5A;
    repeat (3) begin
      @(negedge clock);
      check("wait_busy", 32'(busy), 32'd1);
      check("wait_no_write", 32'(write_enb), 32'd0);
      @(posedge clock);
      #1;
    end
    fifo_empty = 3'b111;
    @(negedge clock);
    check("wait_last_busy", 32'(busy), 32'd1);
    check("wait_last_no_write", 32'(write_enb), 32'd0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("wait_hdr_write", 32'({write_enb, lfd_state, data_out}), 32'({3'b100, 1'b1, 8'h06}));
    @(posedge clock);
    #1;
    send_byte(1'b1, 8'h5A, w);
    send_byte(1'b0, 8'h5C, w);
    @(posedge clock);
    #1;
    check("wait_err", 32'(err), 32'd0);
    check("wait_all_written", 32'(exp_q[2].size()), 32'd0);
    err_m = 1'b0;

    // Unread port 0 times out after 30 cycles and pulses soft_reset once.
    fifo_empty = 3'b110;
    read_enb   = 3'b110;
    for (int e = 1; e <= 31; e++) begin
      @(posedge clock);
      #1;
      if (e == 29) check("timeout_pre", 32'(soft_reset), 32'd0);
      if (e == 30) check("timeout_pulse", 32'(soft_reset), 32'b001);
      if (e == 31) check("timeout_post", 32'(soft_reset), 32'd0);
    end
    fifo_empty = 3'b111;
    read_enb   = 3'b111;
    @(posedge clock);
    #1;

    // Timeout hitting the active port mid-payload aborts the packet into DROP.
    exp_q[0].push_back({1'b1, 8'h10});
    exp_q[0].push_back({1'b0, 8'hAA});
    send_byte(1'b1, 8'h10, w);
    err_m = 1'b0;
    send_byte(1'b1, 8'hAA, w);
    data_in    = 8'hBB;
    fifo_full  = 3'b001;
    fifo_empty = 3'b110;
    read_enb   = 3'b110;
    n = 0;
    while (!soft_reset[0] && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("abort_timeout_cycles", 32'(n), 32'd30);
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_no_write", 32'(write_enb), 32'd0);
    @(posedge clock);
    #1;
    fifo_full  = 3'b000;
    fifo_empty = 3'b111;
    read_enb   = 3'b111;
    #1;
    check("drop_busy", 32'(busy), 32'd0);
    #1;
    send_byte(1'b1, 8'hBB, w);
    check("drop_accept_wait", 32'(w), 32'd0);
    send_byte(1'b1, 8'hCC, w);
    send_byte(1'b0, 8'h00, w);
    @(posedge clock);
    #1;
    check("abort_err_unchanged", 32'(err), 32'(err_m));
    check("abort_queue_empty", 32'(exp_q[0].size()), 32'd0);
    cur_pl.delete();
    cur_pl.push_back(8'h11); cur_pl.push_back(8'h22); cur_pl.push_back(8'h33);
    run_pkt(8'h0D, 8'h0D, -1, 0, es, nw);
    check("after_abort_err", 32'(es), 32'd0);
    check("after_abort_writes", 32'(nw), 32'd5);

    // Asynchronous reset mid-packet.
    exp_q[1].push_back({1'b1, 8'h0D});
    exp_q[1].push_back({1'b0, 8'h11});
    send_byte(1'b1, 8'h0D, w);
    send_byte(1'b1, 8'h11, w);
    data_in = 8'h22;
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_outputs", 32'({write_enb, lfd_state, busy, data_out, err, soft_reset}), 32'd0);
    pkt_valid = 1'b0;
    for (int p = 0; p < 3; p++) exp_q[p].delete();
    err_m = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    run_pkt(8'h0D, 8'h0D, -1, 0, es, nw);
    check("after_rst_err", 32'(es), 32'd0);
    check("after_rst_writes", 32'(nw), 32'd5);

    // Random packets with random full/empty flags.
    rnd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(1, 6);
      a   = 2'($urandom_range(0, 3));
      h   = {6'(len), a};
      acc = h;
      cur_pl.delete();
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom);
        cur_pl.push_back(b);
        acc ^= b;
      end
      par   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : acc;
      exp_e = (a == 2'd3) ? err_m : (par != acc);
      exp_w = (a == 2'd3) ? 0 : len + 2;
      run_pkt(h, par, -1, 0, es, nw);
      check("rnd_err", 32'(es), 32'(exp_e));
      check("rnd_writes", 32'(nw), 32'(exp_w));
    end
    rnd_en = 1'b0;
    @(posedge clock);
    #2;
    fifo_full  = 3'b000;
    fifo_empty = 3'b111;
    repeat (2) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
